// File: rtl/kasumi_fi_seq.sv
// Sequential KASUMI FI engine sharing one S9 and one S7 lookup across the two FI half-rounds.
// Define KASUMI_FI_SYNC_ROM_EN for registered (1-cycle-latency) ROMs; the default build assumes combinational ROMs.
module kasumi_fi_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] din,
    input  logic [15:0] ki,
    output logic        busy,
    output logic        done,
    output logic [15:0] dout,
    output logic [8:0]  s9_addr,
    input  logic [8:0]  s9_data,
    output logic [6:0]  s7_addr,
    input  logic [6:0]  s7_data
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_S9A, ST_S7A, ST_S9B, ST_S7B, ST_DONE,
        ST_W9A, ST_W7A, ST_W9B, ST_W7B
    } state_e;

    // With registered ROMs every lookup is entered through a wait state that presents the address early.
`ifdef KASUMI_FI_SYNC_ROM_EN
    localparam state_e TO_S9A = ST_W9A;
    localparam state_e TO_S7A = ST_W7A;
    localparam state_e TO_S9B = ST_W9B;
    localparam state_e TO_S7B = ST_W7B;
`else
    localparam state_e TO_S9A = ST_S9A;
    localparam state_e TO_S7A = ST_S7A;
    localparam state_e TO_S9B = ST_S9B;
    localparam state_e TO_S7B = ST_S7B;
`endif

    state_e      state_q, state_d;
    logic [8:0]  nine_q, nine_d;
    logic [6:0]  seven_q, seven_d;
    logic [6:0]  ki1_q, ki1_d;
    logic [8:0]  ki2_q, ki2_d;
    logic [15:0] dout_q, dout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: every register is updated with <= so all flops sample the same pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: the default assignment first means no path leaves state_d unassigned, so no latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = TO_S9A;
            ST_W9A:  state_d = ST_S9A;
            ST_S9A:  state_d = TO_S7A;
            ST_W7A:  state_d = ST_S7A;
            ST_S7A:  state_d = TO_S9B;
            ST_W9B:  state_d = ST_S9B;
            ST_S9B:  state_d = TO_S7B;
            ST_W7B:  state_d = ST_S7B;
            ST_S7B:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s9_addr = '0;
        s7_addr = '0;
        busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done    = (state_q == ST_DONE);
        case (state_q)
            ST_W9A, ST_S9A, ST_W9B, ST_S9B: s9_addr = nine_q;
            ST_W7A, ST_S7A, ST_W7B, ST_S7B: s7_addr = seven_q;
            default: ;
        endcase
    end

    // Datapath: lookup results are only consumed in the lookup states, never in the wait states.
    always_comb begin
        nine_d  = nine_q;
        seven_d = seven_q;
        ki1_d   = ki1_q;
        ki2_d   = ki2_q;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    nine_d  = din[15:7];
                    seven_d = din[6:0];
                    ki1_d   = ki[15:9];
                    ki2_d   = ki[8:0];
                end
            end
            ST_S9A, ST_S9B: nine_d = s9_data ^ {2'b00, seven_q};
            ST_S7A: begin
                seven_d = s7_data ^ nine_q[6:0] ^ ki1_q;
                nine_d  = nine_q ^ ki2_q;
            end
            ST_S7B: dout_d = {s7_data ^ nine_q[6:0], nine_q};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nine_q  <= '0;
            seven_q <= '0;
            ki1_q   <= '0;
            ki2_q   <= '0;
            dout_q  <= '0;
        end else begin
            nine_q  <= nine_d;
            seven_q <= seven_d;
            ki1_q   <= ki1_d;
            ki2_q   <= ki2_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_kasumi_fi_seq.sv
// Self-checking bench for kasumi_fi_seq: S9 table model, identity S7, scoreboard of expected results.
// Builds against either ROM timing; KASUMI_FI_SYNC_ROM_EN selects the registered ROM model.
module tb_kasumi_fi_seq;

`ifdef KASUMI_FI_SYNC_ROM_EN
    localparam int LAT     = 8;
    localparam int S7A_OFS = 3;
    localparam int S9B_OFS = 5;
`else
    localparam int LAT     = 4;
    localparam int S7A_OFS = 1;
    localparam int S9B_OFS = 2;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] din;
    logic [15:0] ki;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic [8:0]  s9_addr;
    logic [8:0]  s9_data;
    logic [6:0]  s7_addr;
    logic [6:0]  s7_data;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          start_cyc = 0;
    int          done_cnt  = 0;
    logic [15:0] exp_q[$];

    kasumi_fi_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .din     (din),
        .ki      (ki),
        .busy    (busy),
        .done    (done),
        .dout    (dout),
        .s9_addr (s9_addr),
        .s9_data (s9_data),
        .s7_addr (s7_addr),
        .s7_data (s7_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Entries used by the directed vectors come from the S9 table; other addresses get a fixed filler.
    function automatic logic [8:0] s9_tab(input logic [8:0] a);
        case (a)
            9'd0:    return 9'd167;
            9'd166:  return 9'd324;
            9'd167:  return 9'd24;
            default: return (a * 9'd181) ^ 9'h0A5 ^ (a >> 3);
        endcase
    endfunction

    function automatic logic [6:0] s7_tab(input logic [6:0] a);
        return a;
    endfunction

    function automatic logic [15:0] fi_ref(input logic [15:0] d, input logic [15:0] k);
        logic [8:0] nine;
        logic [6:0] seven;
        nine  = d[15:7];
        seven = d[6:0];
        nine  = s9_tab(nine) ^ {2'b00, seven};
        seven = s7_tab(seven) ^ nine[6:0] ^ k[15:9];
        nine  = nine ^ k[8:0];
        nine  = s9_tab(nine) ^ {2'b00, seven};
        seven = s7_tab(seven) ^ nine[6:0];
        return {seven, nine};
    endfunction

`ifdef KASUMI_FI_SYNC_ROM_EN
    always @(posedge clk) begin
        s9_data <= s9_tab(s9_addr);
        s7_data <= s7_tab(s7_addr);
    end
`else
    always_comb begin
        s9_data = s9_tab(s9_addr);
        s7_data = s7_tab(s7_addr);
    end
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else                   check("dout", dout, exp_q.pop_front());
        end
    end

    // Called #1 after a posedge while the DUT is idle; returns #1 after the accepting edge.
    task automatic launch(input logic [15:0] d, input logic [15:0] k, input logic [15:0] exp);
        start = 1'b1;
        din   = d;
        ki    = k;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
        din   = 16'($urandom);
        ki    = 16'($urandom);
    endtask

    task automatic wait_done(output int done_at);
        bit seen;
        seen    = 1'b0;
        done_at = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen    = 1'b1;
                done_at = cyc;
            end
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", done_at - start_cyc, LAT);
            check("busy_in_done", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int d1, d2, n_before;
        logic [15:0] rd, rk;
        rst_n = 1'b0;
        start = 1'b0;
        din   = '0;
        ki    = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_s9_addr", s9_addr, 32'd0);
        check("rst_s7_addr", s7_addr, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All-zero input and key.
        launch(16'h0000, 16'h0000, 16'h303F);
        @(negedge clk);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_s9a_addr", s9_addr, 32'd0);
        repeat (S9B_OFS) @(negedge clk);
        check("t1_s9b_addr", s9_addr, 32'd167);
        wait_done(d1);
        @(negedge clk);
        check("t1_done_one_cycle", {31'd0, done}, 32'd0);
        check("t1_dout_hold", dout, 32'h303F);
        @(posedge clk);
        #1;

        // KI2 = 1 perturbs the second S9 lookup.
        launch(16'h0000, 16'h0001, 16'h8963);
        repeat (S9B_OFS + 1) @(negedge clk);
        check("t2_s9b_addr", s9_addr, 32'd166);
        wait_done(d1);
        @(posedge clk);
        #1;

        // A second start during S7A must be ignored.
        n_before = done_cnt;
        launch(16'h1234, 16'h5678, fi_ref(16'h1234, 16'h5678));
        repeat (S7A_OFS) @(posedge clk);
        #1;
        start = 1'b1;
        din   = 16'hABCD;
        ki    = 16'h0F0F;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(d1);
        repeat (LAT + 4) @(negedge clk);
        check("t3_single_done", done_cnt - n_before, 32'd1);
        @(posedge clk);
        #1;

        // Reset asserted in S9B discards the operation.
        launch(16'hBEEF, 16'hCAFE, 16'h0000);
        repeat (S9B_OFS) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_done", {31'd0, done}, 32'd0);
        check("t4_dout", dout, 32'd0);
        check("t4_s9_addr", s9_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        launch(16'h0000, 16'h0001, 16'h8963);
        wait_done(d1);
        @(posedge clk);
        #1;

        // Back-to-back: restart in the IDLE cycle right after DONE.
        launch(16'h0000, 16'h0000, 16'h303F);
        wait_done(d1);
        @(posedge clk);
        #1;
        launch(16'h4321, 16'h8765, fi_ref(16'h4321, 16'h8765));
        wait_done(d2);
        check("t5_gap", d2 - d1, LAT + 2);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            rd = 16'($urandom);
            rk = 16'($urandom);
            launch(rd, rk, fi_ref(rd, rk));
            wait_done(d1);
            @(posedge clk);
            #1;
        end

        repeat (LAT + 4) @(negedge clk);
        check("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
